// File: rtl/xbar_router.sv
// Destination-addressed crossbar: every input names the output it targets,
// each output picks one requester round-robin and registers it behind valid/ready.
module xbar_router #(
    parameter int ELEM_WIDTH = 4,
    parameter int NUM_ELEM   = 5
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0]        i_data_i,
    input  logic [NUM_ELEM-1:0][$clog2(NUM_ELEM)-1:0]  i_dest_i,
    input  logic [NUM_ELEM-1:0]                        i_valid_i,
    output logic [NUM_ELEM-1:0]                        i_ready_o,
    output logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0]        o_data_o,
    output logic [NUM_ELEM-1:0][$clog2(NUM_ELEM)-1:0]  o_src_o,
    output logic [NUM_ELEM-1:0]                        o_valid_o,
    input  logic [NUM_ELEM-1:0]                        o_ready_i,
    output logic [NUM_ELEM-1:0]                        drop_o
);
    localparam int SelWidth = $clog2(NUM_ELEM);
    localparam logic [SelWidth-1:0] LastIdx  = SelWidth'(NUM_ELEM - 1);
    localparam logic [SelWidth:0]   NumElemW = (SelWidth + 1)'(NUM_ELEM);

    logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0] r_data;
    logic [NUM_ELEM-1:0][SelWidth-1:0]   r_src;
    logic [NUM_ELEM-1:0][SelWidth-1:0]   r_ptr;
    logic [NUM_ELEM-1:0]                 r_valid;
    logic [NUM_ELEM-1:0]                 r_drop;

    logic [NUM_ELEM-1:0]                 w_space;
    logic [NUM_ELEM-1:0]                 w_gnt;
    logic [NUM_ELEM-1:0][SelWidth-1:0]   w_win;
    logic [NUM_ELEM-1:0]                 w_illegal;
    logic [NUM_ELEM-1:0]                 w_ready;

    assign w_space = ~r_valid | o_ready_i;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ELEM; gi++) begin : g_arb
            logic [NUM_ELEM-1:0] w_req;
            logic                w_any;
            logic [SelWidth-1:0] w_sel;

            always_comb begin
                for (int i = 0; i < NUM_ELEM; i++) begin
                    w_req[i] = i_valid_i[i] && (i_dest_i[i] == SelWidth'(gi));
                end
            end

            // Scan farthest-to-nearest so the requester closest to the pointer is kept.
            always_comb begin
                int idx;
                w_any = 1'b0;
                w_sel = '0;
                for (int k = NUM_ELEM - 1; k >= 0; k--) begin
                    idx = int'(r_ptr[gi]) + k;
                    if (idx >= NUM_ELEM) begin
                        idx = idx - NUM_ELEM;
                    end
                    if (w_req[idx]) begin
                        w_any = 1'b1;
                        w_sel = SelWidth'(idx);
                    end
                end
            end

            assign w_gnt[gi] = w_any && w_space[gi] && !rst_i;
            assign w_win[gi] = w_sel;
        end
    endgenerate

    // Illegal destinations are always accepted so they never block the producer.
    always_comb begin
        for (int i = 0; i < NUM_ELEM; i++) begin
            w_illegal[i] = ({1'b0, i_dest_i[i]} >= NumElemW);
            w_ready[i]   = 1'b0;
            if (!rst_i && i_valid_i[i]) begin
                if (w_illegal[i]) begin
                    w_ready[i] = 1'b1;
                end else begin
                    w_ready[i] = w_gnt[i_dest_i[i]] && (w_win[i_dest_i[i]] == SelWidth'(i));
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_data  <= '0;
            r_src   <= '0;
            r_ptr   <= '0;
            r_drop  <= '0;
        end else begin
            for (int j = 0; j < NUM_ELEM; j++) begin
                if (w_gnt[j]) begin
                    r_valid[j] <= 1'b1;
                    r_data[j]  <= i_data_i[w_win[j]];
                    r_src[j]   <= w_win[j];
                    r_ptr[j]   <= (w_win[j] == LastIdx) ? '0 : w_win[j] + 1'b1;
                end else if (o_ready_i[j]) begin
                    r_valid[j] <= 1'b0;
                end
            end
            r_drop <= i_valid_i & w_illegal;
        end
    end

    assign i_ready_o = w_ready;
    assign o_data_o  = r_data;
    assign o_src_o   = r_src;
    assign o_valid_o = r_valid;
    assign drop_o    = r_drop;

endmodule

// File: tb/tb_xbar_router.sv
// Randomized and directed bench for xbar_router against a cycle-level reference
// model of the routing rules plus a per-(src,dest) ordering scoreboard.
module tb_xbar_router;
    localparam int N  = 5;
    localparam int W  = 4;
    localparam int SW = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0][W-1:0]   in_data;
    logic [N-1:0][SW-1:0]  in_dest;
    logic [N-1:0]          in_valid;
    logic [N-1:0]          i_ready;
    logic [N-1:0][W-1:0]   out_data;
    logic [N-1:0][SW-1:0]  out_src;
    logic [N-1:0]          out_valid;
    logic [N-1:0]          o_ready;
    logic [N-1:0]          drop;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what each output register should hold.
    logic [N-1:0]          m_valid;
    logic [N-1:0][W-1:0]   m_data;
    logic [N-1:0][SW-1:0]  m_src;
    logic [N-1:0]          m_drop;
    int                    m_ptr [N];
    logic [N-1:0]          s_rdy;
    logic [W-1:0]          sb_q [N][N][$];

    always #5 clk = ~clk;

    xbar_router #(.ELEM_WIDTH(W), .NUM_ELEM(N)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .i_data_i  (in_data),
        .i_dest_i  (in_dest),
        .i_valid_i (in_valid),
        .i_ready_o (i_ready),
        .o_data_o  (out_data),
        .o_src_o   (out_src),
        .o_valid_o (out_valid),
        .o_ready_i (o_ready),
        .drop_o    (drop)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: check registered outputs and ready at negedge, then advance the model.
    task automatic cycle();
        logic [N-1:0]         nv;
        logic [N-1:0][W-1:0]  nd;
        logic [N-1:0][SW-1:0] ns;
        logic [N-1:0]         erdy;
        logic [N-1:0]         ndrop;
        int                   np [N];
        int                   win;
        int                   idx;
        logic                 was_rst;
        @(negedge clk);
        check_val("o_valid", 32'(out_valid), 32'(m_valid));
        check_val("o_data", 32'(out_data), 32'(m_data));
        check_val("o_src", 32'(out_src), 32'(m_src));
        check_val("drop", 32'(drop), 32'(m_drop));
        nv = m_valid; nd = m_data; ns = m_src; erdy = '0; ndrop = '0;
        for (int j = 0; j < N; j++) begin
            np[j] = m_ptr[j];
            win = -1;
            if (!rst && (!m_valid[j] || o_ready[j])) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr[j] + k) % N;
                    if (win < 0 && in_valid[idx] && int'(in_dest[idx]) == j) win = idx;
                end
            end
            if (win >= 0) begin
                erdy[win] = 1'b1;
                nv[j] = 1'b1;
                nd[j] = in_data[win];
                ns[j] = SW'(win);
                np[j] = (win + 1) % N;
            end else if (o_ready[j]) begin
                nv[j] = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!rst && in_valid[i] && int'(in_dest[i]) >= N) begin
                erdy[i]  = 1'b1;
                ndrop[i] = 1'b1;
            end
        end
        check_val("i_ready", 32'(i_ready), 32'(erdy));
        s_rdy = i_ready;
        for (int j = 0; j < N; j++) begin
            if (out_valid[j] && o_ready[j] && int'(out_src[j]) < N) begin
                check_val("sb_avail", 32'(sb_q[out_src[j]][j].size() > 0), 32'd1);
                if (sb_q[out_src[j]][j].size() > 0)
                    check_val("sb_data", 32'(out_data[j]), 32'(sb_q[out_src[j]][j].pop_front()));
            end
        end
        for (int i = 0; i < N; i++) begin
            if (in_valid[i] && i_ready[i] && int'(in_dest[i]) < N)
                sb_q[i][in_dest[i]].push_back(in_data[i]);
        end
        was_rst = rst;
        @(posedge clk);
        if (was_rst) begin
            m_valid = '0; m_data = '0; m_src = '0; m_drop = '0;
            for (int j = 0; j < N; j++) begin
                m_ptr[j] = 0;
                for (int i = 0; i < N; i++) sb_q[i][j].delete();
            end
        end else begin
            m_valid = nv; m_data = nd; m_src = ns; m_drop = ndrop;
            for (int j = 0; j < N; j++) m_ptr[j] = np[j];
        end
        #1;
    endtask

    task automatic idle();
        in_valid = '0;
        o_ready  = '1;
    endtask

    initial begin
        int rr_exp [6] = '{1, 3, 4, 1, 3, 4};
        logic [N-1:0][W-1:0] pe;
        int leftover;

        m_valid = '0; m_data = '0; m_src = '0; m_drop = '0; s_rdy = '0;
        for (int j = 0; j < N; j++) m_ptr[j] = 0;
        rst = 1'b1;
        o_ready = '1;
        in_valid = '1;
        for (int i = 0; i < N; i++) begin
            in_data[i] = W'($urandom);
            in_dest[i] = SW'(i);
        end
        #1;
        cycle();
        cycle();
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_rdy", 32'(s_rdy), 32'd0);
        rst = 1'b0;
        idle();

        // Single path: input 2 -> output 4.
        in_valid[2] = 1'b1; in_dest[2] = 3'd4; in_data[2] = 4'hA;
        cycle();
        check_val("p1_rdy", 32'(s_rdy[2]), 32'd1);
        check_val("p1_oval", 32'(out_valid), 32'b10000);
        check_val("p1_data", 32'(out_data[4]), 32'hA);
        check_val("p1_src", 32'(out_src[4]), 32'd2);
        idle();
        cycle();

        // Contention on output 0 after a fresh reset.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        in_valid = 5'b11010;
        in_dest[1] = 3'd0; in_data[1] = 4'h1;
        in_dest[3] = 3'd0; in_data[3] = 4'h3;
        in_dest[4] = 3'd0; in_data[4] = 4'h4;
        for (int c = 0; c < 6; c++) begin
            cycle();
            check_val("rr_src", 32'(out_src[0]), 32'(rr_exp[c]));
            check_val("rr_data", 32'(out_data[0]), 32'(rr_exp[c]));
        end
        idle();
        cycle();

        // Backpressure on output 2.
        in_valid[0] = 1'b1; in_dest[0] = 3'd2; in_data[0] = 4'h7;
        o_ready[2] = 1'b0;
        cycle();
        in_data[0] = 4'h9;
        for (int c = 0; c < 5; c++) begin
            cycle();
            check_val("bp_rdy", 32'(s_rdy[0]), 32'd0);
            check_val("bp_data", 32'(out_data[2]), 32'h7);
            check_val("bp_val", 32'(out_valid[2]), 32'd1);
        end
        o_ready[2] = 1'b1;
        cycle();
        check_val("bp_rel_rdy", 32'(s_rdy[0]), 32'd1);
        check_val("bp_rel_data", 32'(out_data[2]), 32'h9);
        check_val("bp_rel_src", 32'(out_src[2]), 32'd0);
        idle();
        cycle();

        // Full permutation i -> (i+1)%N.
        in_valid = '1;
        for (int c = 0; c < 100; c++) begin
            for (int i = 0; i < N; i++) begin
                in_dest[i] = SW'((i + 1) % N);
                in_data[i] = W'($urandom);
                pe[(i + 1) % N] = in_data[i];
            end
            cycle();
            check_val("perm_rdy", 32'(s_rdy), 32'h1F);
            check_val("perm_data", 32'(out_data), 32'(pe));
            check_val("perm_drop", 32'(drop), 32'd0);
        end
        idle();
        cycle();

        // Illegal destination.
        in_valid[3] = 1'b1; in_dest[3] = 3'd6; in_data[3] = 4'h5;
        cycle();
        check_val("ill_rdy", 32'(s_rdy[3]), 32'd1);
        check_val("ill_drop", 32'(drop), 32'b01000);
        check_val("ill_oval", 32'(out_valid), 32'd0);
        idle();
        cycle();

        // Reset with three outputs full and stalled, then round-robin restart.
        in_valid = 5'b00111;
        for (int i = 0; i < 3; i++) begin
            in_dest[i] = SW'(i);
            in_data[i] = W'(i + 8);
        end
        o_ready = '0;
        cycle();
        check_val("mr_full", 32'(out_valid), 32'b00111);
        rst = 1'b1;
        cycle();
        check_val("mr_rdy", 32'(s_rdy), 32'd0);
        check_val("mr_oval", 32'(out_valid), 32'd0);
        check_val("mr_odata", 32'(out_data), 32'd0);
        check_val("mr_osrc", 32'(out_src), 32'd0);
        rst = 1'b0;
        o_ready = '1;
        in_valid = 5'b01001;
        in_dest[0] = 3'd0; in_data[0] = 4'hC;
        in_dest[3] = 3'd0; in_data[3] = 4'hD;
        cycle();
        check_val("mr_rr0", 32'(out_src[0]), 32'd0);
        cycle();
        check_val("mr_rr1", 32'(out_src[0]), 32'd3);
        idle();
        cycle();

        // Random soak.
        for (int c = 0; c < 10000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < N; i++) begin
                in_valid[i] = ($urandom_range(0, 9) < 6);
                in_dest[i]  = SW'($urandom_range(0, 7));
                in_data[i]  = W'($urandom);
                o_ready[i]  = ($urandom_range(0, 9) < 7);
            end
            cycle();
        end
        rst = 1'b0;
        idle();
        for (int c = 0; c < 4; c++) cycle();
        leftover = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) leftover += sb_q[i][j].size();
        check_val("sb_leftover", 32'(leftover), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
